// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory-mapped slave backed by an on-chip word array. Supports FIXED/INCR/WRAP
// bursts, byte-strobed writes, a configurable read latency and per-burst error responses.
module axi4_burst_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_DATA} r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_INCR: next_addr = addr + inc;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + inc) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

  // Whole-burst legality, decided once from the address phase. The highest beat
  // address bounds every beat's word index, so only that one is range-checked.
  function automatic logic burst_error(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
    logic [ADDR_WIDTH:0] lo;
    logic [ADDR_WIDTH:0] hi;
    logic [ADDR_WIDTH:0] inc;
    logic [ADDR_WIDTH:0] total;
    logic                err;
    inc   = (ADDR_WIDTH+1)'(1) << size;
    total = ((ADDR_WIDTH+1)'(len) + (ADDR_WIDTH+1)'(1)) << size;
    lo    = {1'b0, addr};
    hi    = lo;
    err   = (size > 3'(SHIFT));
    case (burst)
      BURST_FIXED: hi = lo;
      BURST_INCR: begin
        hi = lo + ((ADDR_WIDTH+1)'(len) << size);
        if ((hi >> 12) != (lo >> 12)) err = 1'b1;
      end
      BURST_WRAP: begin
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((lo & (inc - 1'b1)) != '0)) err = 1'b1;
        lo = lo & ~(total - 1'b1);
        hi = lo + total - inc;
      end
      default: err = 1'b1;  // reserved burst encoding
    endcase
    if (32'(hi >> SHIFT) >= 32'(MEMORY_DEPTH)) err = 1'b1;
    return err;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // ---------------- write channel ----------------
  w_state_e              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_bad;
  logic                  w_last;
  logic [IDX_W-1:0]      w_idx;

  assign w_last = (w_cnt == w_len);
  assign w_idx  = IDX_W'(w_addr >> SHIFT);
  assign BRESP  = (BVALID && (w_err || w_bad)) ? RESP_SLVERR : RESP_OKAY;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = w_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_bad   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && AWVALID) begin
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= burst_error(AWADDR, AWLEN, AWSIZE, AWBURST);
        w_bad   <= 1'b0;
      end else if (w_state == W_DATA && WVALID) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (WLAST != w_last) w_bad <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [LAT_W-1:0]      r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]      r_idx;

  assign r_idx = IDX_W'(r_addr >> SHIFT);
  assign RRESP = (RVALID && r_err) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    r_state_nxt = r_state;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_nxt = R_FETCH;
      end
      R_FETCH: r_state_nxt = R_WAIT;
      R_WAIT:  if (r_wait_cnt == LAT_W'(READ_LATENCY - 1)) r_state_nxt = R_DATA;
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) r_state_nxt = (r_cnt == r_len) ? R_IDLE : R_FETCH;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
      RDATA      <= '0;
      RLAST      <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      case (r_state)
        R_IDLE: if (ARVALID) begin
          r_addr  <= ARADDR;
          r_len   <= ARLEN;
          r_size  <= ARSIZE;
          r_burst <= ARBURST;
          r_cnt   <= '0;
          r_err   <= burst_error(ARADDR, ARLEN, ARSIZE, ARBURST);
        end
        R_FETCH: r_wait_cnt <= '0;
        R_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (r_state_nxt == R_DATA) begin
            RDATA <= r_err ? '0 : r_word;
            RLAST <= (r_cnt == r_len);
          end
        end
        R_DATA: if (RREADY) begin
          RLAST  <= 1'b0;
          r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
          r_cnt  <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; its contents survive ARESETn by design.
  // A read and write of the same word at one edge returns the pre-write data.
  always_ff @(posedge ACLK) begin
    if (w_state == W_DATA && WVALID && !w_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
    if (r_state == R_FETCH && !r_err) r_word <= mem[r_idx];
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: burst types, strobes, errors, read latency/stall, reset.
module tb_axi4_burst_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [15:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  axi4_burst_mem_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024), .READ_LATENCY(2)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_awready"}, 64'(AWREADY), 64'd1);
    check({pfx, "_arready"}, 64'(ARREADY), 64'd1);
    check({pfx, "_wready"},  64'(WREADY),  64'd0);
    check({pfx, "_bvalid"},  64'(BVALID),  64'd0);
    check({pfx, "_bresp"},   64'(BRESP),   64'd0);
    check({pfx, "_rvalid"},  64'(RVALID),  64'd0);
    check({pfx, "_rresp"},   64'(RRESP),   64'd0);
    check({pfx, "_rdata"},   64'(RDATA),   64'd0);
    check({pfx, "_rlast"},   64'(RLAST),   64'd0);
  endtask

  // All channel tasks start and end on a falling edge.
  task automatic aw_send(input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && cyc < 100) begin @(negedge ACLK); cyc++; end
    if (cyc >= 100) check("aw_timeout", 64'(AWREADY), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int cyc = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!WREADY && cyc < 100) begin @(negedge ACLK); cyc++; end
    if (cyc >= 100) check("w_timeout", 64'(WREADY), 64'd1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp);
    int cyc = 0;
    BREADY = 1'b1;
    while (!BVALID && cyc < 100) begin @(negedge ACLK); cyc++; end
    if (cyc >= 100) check("b_timeout", 64'(BVALID), 64'd1);
    resp = BRESP;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic ar_send(input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && cyc < 100) begin @(negedge ACLK); cyc++; end
    if (cyc >= 100) check("ar_timeout", 64'(ARREADY), 64'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic r_recv(output logic [31:0] data, output logic [1:0] resp, output logic last);
    int cyc = 0;
    RREADY = 1'b1;
    while (!RVALID && cyc < 100) begin @(negedge ACLK); cyc++; end
    if (cyc >= 100) check("r_timeout", 64'(RVALID), 64'd1);
    data = RDATA; resp = RRESP; last = RLAST;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic write_single(input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp);
    aw_send(addr, 8'd0, 3'd2, 2'b01);
    w_beat(data, strb, 1'b1);
    b_recv(resp);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] t1_exp [4];
    int          lat;

    // Reset state
    #12;
    check_reset_outputs("rst0");
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // 1: WRAP write from 0x0C wraps to 0x00; INCR read back from 0x00
    aw_send(16'h000C, 8'd3, 3'd2, 2'b10);
    w_beat(32'hAAAA_000A, 4'hF, 1'b0);
    w_beat(32'hBBBB_000B, 4'hF, 1'b0);
    w_beat(32'hCCCC_000C, 4'hF, 1'b0);
    w_beat(32'hDDDD_000D, 4'hF, 1'b1);
    b_recv(resp);
    check("t1_bresp", 64'(resp), 64'd0);
    t1_exp = '{32'hBBBB_000B, 32'hCCCC_000C, 32'hDDDD_000D, 32'hAAAA_000A};
    ar_send(16'h0000, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, resp, last);
      check($sformatf("t1_rdata%0d", i), 64'(d), 64'(t1_exp[i]));
      check($sformatf("t1_rresp%0d", i), 64'(resp), 64'd0);
      check($sformatf("t1_rlast%0d", i), 64'(last), 64'(i == 3));
    end

    // WRAP with illegal length 3 beats: SLVERR, no writes
    aw_send(16'h0000, 8'd2, 3'd2, 2'b10);
    w_beat(32'h0BAD_0001, 4'hF, 1'b0);
    w_beat(32'h0BAD_0002, 4'hF, 1'b0);
    w_beat(32'h0BAD_0003, 4'hF, 1'b1);
    b_recv(resp);
    check("wrap_len_bresp", 64'(resp), 64'd2);
    ar_send(16'h0000, 8'd0, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("wrap_len_mem", 64'(d), 64'h0000_0000_BBBB_000B);

    // 2: byte strobes
    write_single(16'h0020, 32'hFFFF_FFFF, 4'hF, resp);
    check("t2_bresp_a", 64'(resp), 64'd0);
    write_single(16'h0020, 32'h1234_5678, 4'b0101, resp);
    check("t2_bresp_b", 64'(resp), 64'd0);
    ar_send(16'h0020, 8'd0, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("t2_rdata", 64'(d), 64'h0000_0000_FF34_FF78);
    check("t2_rlast", 64'(last), 64'd1);

    // 3: FIXED burst overwrites a single word
    write_single(16'h0014, 32'hCAFE_F00D, 4'hF, resp);
    aw_send(16'h0010, 8'd2, 3'd2, 2'b00);
    w_beat(32'd1, 4'hF, 1'b0);
    w_beat(32'd2, 4'hF, 1'b0);
    w_beat(32'd3, 4'hF, 1'b1);
    b_recv(resp);
    check("t3_bresp", 64'(resp), 64'd0);
    ar_send(16'h0010, 8'd1, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("t3_rdata0", 64'(d), 64'd3);
    r_recv(d, resp, last);
    check("t3_rdata1", 64'(d), 64'h0000_0000_CAFE_F00D);
    check("t3_rlast1", 64'(last), 64'd1);

    // 4: INCR crossing 4KB -> SLVERR on write and read, memory untouched
    write_single(16'h0FF8, 32'h1111_1111, 4'hF, resp);
    write_single(16'h0FFC, 32'h2222_2222, 4'hF, resp);
    aw_send(16'h0FF8, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hDEAD_0000 + 32'(i), 4'hF, i == 3);
    b_recv(resp);
    check("t4_bresp", 64'(resp), 64'd2);
    ar_send(16'h0FF8, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, resp, last);
      check($sformatf("t4_rdata%0d", i), 64'(d), 64'd0);
      check($sformatf("t4_rresp%0d", i), 64'(resp), 64'd2);
      check($sformatf("t4_rlast%0d", i), 64'(last), 64'(i == 3));
    end
    ar_send(16'h0FF8, 8'd1, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("t4_keep0", 64'(d), 64'h0000_0000_1111_1111);
    check("t4_keep_resp", 64'(resp), 64'd0);
    r_recv(d, resp, last);
    check("t4_keep1", 64'(d), 64'h0000_0000_2222_2222);

    // Preload words used by the reset test
    write_single(16'h0048, 32'h4848_4848, 4'hF, resp);
    write_single(16'h004C, 32'h4C4C_4C4C, 4'hF, resp);

    // 5: read latency and stall stability
    ARADDR = 16'h0020; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    check("t5_arready", 64'(ARREADY), 64'd1);
    @(posedge ACLK);
    #1 ARVALID = 1'b0;
    lat = 0;
    while (!RVALID && lat < 50) begin @(posedge ACLK); #1; lat++; end
    check("t5_latency", 64'(lat), 64'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check($sformatf("t5_hold_rvalid%0d", k), 64'(RVALID), 64'd1);
      check($sformatf("t5_hold_rdata%0d", k), 64'(RDATA), 64'h0000_0000_FF34_FF78);
      check($sformatf("t5_hold_rlast%0d", k), 64'(RLAST), 64'd1);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("t5_rvalid_drop", 64'(RVALID), 64'd0);
    check("t5_arready_back", 64'(ARREADY), 64'd1);

    // 6: reset in the middle of a 4-beat write
    aw_send(16'h0040, 8'd3, 3'd2, 2'b01);
    w_beat(32'h0A0A_0001, 4'hF, 1'b0);
    w_beat(32'h0A0A_0002, 4'hF, 1'b0);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    ar_send(16'h0040, 8'd3, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("t6_rdata0", 64'(d), 64'h0000_0000_0A0A_0001);
    r_recv(d, resp, last);
    check("t6_rdata1", 64'(d), 64'h0000_0000_0A0A_0002);
    r_recv(d, resp, last);
    check("t6_rdata2", 64'(d), 64'h0000_0000_4848_4848);
    r_recv(d, resp, last);
    check("t6_rdata3", 64'(d), 64'h0000_0000_4C4C_4C4C);
    check("t6_rlast3", 64'(last), 64'd1);
    write_single(16'h0050, 32'h5A5A_5A5A, 4'hF, resp);
    check("t6_post_bresp", 64'(resp), 64'd0);
    ar_send(16'h0050, 8'd0, 3'd2, 2'b01);
    r_recv(d, resp, last);
    check("t6_post_rdata", 64'(d), 64'h0000_0000_5A5A_5A5A);
    check("t6_post_rresp", 64'(resp), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
Second-generation AXI4 memory-mapped slave with an on-chip word memory. Adds FIXED/INCR/WRAP burst types, WSTRB byte-lane writes, a parametrised read latency and per-burst error checking. Sits behind the AXI4 interconnect as a verification target. Read and write channels run independently.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
ADDR_WIDTH, 16, byte address width.
MEMORY_DEPTH, 1024, number of DATA_WIDTH words; word index = addr >> log2(DATA_WIDTH/8).
READ_LATENCY, 2, cycles from memory read issue to data capture; minimum 1.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write start byte address
AWLEN  in  8  beats-1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWVALID/AWREADY  in/out  1  write address handshake
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte-lane enables
WLAST  in  1  final write beat marker
WVALID/WREADY  in/out  1  write data handshake
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID/BREADY  out/in  1  write response handshake
ARADDR, ARLEN, ARSIZE, ARBURST  in  ADDR_WIDTH, 8, 3, 2  read address fields, encoded as AW*
ARVALID/ARREADY  in/out  1  read address handshake
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  final read beat
RVALID/RREADY  out/in  1  read data handshake

Behaviour:
- Reset values: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, BRESP=00, RVALID=0, RRESP=00, RDATA=0, RLAST=0. Memory contents are not cleared. Reset mid-burst aborts it; beats already written remain.
- Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. In W_IDLE, AW handshake captures addr/len/size/burst and drops AWREADY. WREADY rises the next cycle. Each W handshake writes bytes where WSTRB[i]=1 unless the burst is in error. Beat AWLEN+1 ends the burst regardless of WLAST. BVALID rises the cycle after the last beat and holds until BREADY. AWREADY is re-asserted after the B handshake.
- Write errors are evaluated once, at AW capture, and give SLVERR with no memory writes for the whole burst:
  - any beat word index >= MEMORY_DEPTH;
  - INCR burst crossing a 4KB boundary;
  - AWSIZE > log2(DATA_WIDTH/8);
  - WRAP with AWLEN not in {1,3,7,15} or start address not size-aligned.
- WLAST mismatch (asserted early, or absent on the final beat) also gives SLVERR; beats already written stay.
- Next-address rules, with inc = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr+inc, modulo 2^ADDR_WIDTH.
  - WRAP: total=(len+1)<<size; next=(addr & ~(total-1)) | ((addr+inc) & (total-1)).
- Read FSM R_IDLE->R_FETCH->R_WAIT->R_DATA.
  - AR handshake drops ARREADY; R_FETCH issues the memory read.
  - R_WAIT counts READ_LATENCY cycles.
  - R_DATA asserts RVALID; first RVALID is exactly READ_LATENCY+1 cycles after the AR handshake.
  - RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0.
  - After each R handshake, RVALID drops and the next beat repeats the FETCH/WAIT sequence.
  - RLAST=1 only on beat ARLEN+1; ARREADY is re-asserted after that beat.
- Read errors use the same checks as writes: every beat returns RDATA=0 and RRESP=10, RLAST is still correct, and no memory access is made.
- The same word read and written in the same cycle returns the old data (read-before-write). Channels never stall each other.

Test Plan:
1. WRAP write AWADDR=0x0C, LEN=3, SIZE=2, data A,B,C,D -> BRESP=00. INCR read 0x00 LEN=3 -> B,C,D,A; RLAST on beat 4 only.
2. Write 0xFFFFFFFF to 0x20, then 0x12345678 with WSTRB=0101 -> read 0x20 returns 0xFF34FF78.
3. FIXED write 0x10, LEN=2, data 1,2,3 -> read 0x10 returns 3; 0x14 unchanged.
4. INCR write 0x0FF8, LEN=3, SIZE=2 (crosses 4KB) -> BRESP=10, memory unchanged. Same read -> 4 beats, RRESP=10, RDATA=0, RLAST on beat 4.
5. READ_LATENCY=2: RVALID exactly 3 cycles after AR handshake. Hold RREADY low for 5 cycles -> RDATA/RLAST constant and RVALID stays high.
6. Assert ARESETn low after 2 of 4 write beats -> all outputs at reset values next edge; first 2 words updated. A following write/read pair completes OKAY.
